// File: rtl/boot_mem.sv
// Run-time loadable boot memory: a streamed image fills a single-port RAM that the
// CPU then reads (and, with RW=1, writes) once the load has completed.
module boot_mem #(
  parameter int              KB    = 16,
  parameter int              DW    = 8,
  parameter int              RW    = 0,
  parameter logic [DW-1:0]   FILL  = '1,
  localparam int             DEPTH = KB * 1024,
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   len,
  input  logic [AW-1:0] a,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          rd_ok_q, rd_ok_d;

  logic          addr_ok;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] mem [DEPTH];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned
  // (otherwise synthesis infers a latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mem_we    = 1'b0;
    mem_addr  = a;
    mem_wdata = d;
    addr_ok   = {1'b0, a} < len_q;
    rd_ok_d   = (state_q == S_DONE) && addr_ok;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        // The single RAM port belongs to the load stream for the whole load.
        mem_addr  = cnt_q;
        mem_wdata = ld_data;
        if (ld_valid) begin
          mem_we = 1'b1;
          if (ld_last || (cnt_q == AW'(DEPTH - 1))) begin
            // Counter holds on the final word so it can never wrap back to address 0.
            state_d = S_DONE;
            len_d   = {1'b0, cnt_q} + (AW + 1)'(1);
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      S_DONE: begin
        mem_we = (RW != 0) && we && addr_ok;
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  // NOTE: the RAM array and its read register have no reset so the tools can map
  // them onto block RAM; rd_ok_q masks stale contents instead.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end

  assign ld_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign len      = len_q;
  assign q        = rd_ok_q ? rd_q : FILL;

endmodule

// File: tb/tb_boot_mem.sv
// Self-checking bench for boot_mem: constant tables for the short-load and RW
// corner cases plus random load/read traffic against an image-level reference model.
module tb_boot_mem;

  localparam int          DEPTH = 1024;
  localparam logic [7:0]  FILL  = 8'hFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic [9:0]  a = '0;
  logic        we = 1'b0;
  logic [7:0]  d = '0;

  logic        ro_ld_ready, ro_busy, ro_done;
  logic [10:0] ro_len;
  logic [7:0]  ro_q;
  logic        rw_ld_ready, rw_busy, rw_done;
  logic [10:0] rw_len;
  logic [7:0]  rw_q;

  boot_mem #(.KB(1), .DW(8), .RW(0)) u_ro (
    .clock(clock), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ro_ld_ready),
    .busy(ro_busy), .done(ro_done), .len(ro_len),
    .a(a), .we(we), .d(d), .q(ro_q)
  );

  boot_mem #(.KB(1), .DW(8), .RW(1)) u_rw (
    .clock(clock), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(rw_ld_ready),
    .busy(rw_busy), .done(rw_done), .len(rw_len),
    .a(a), .we(we), .d(d), .q(rw_q)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: image contents per instance, words loaded so far, published length.
  logic [7:0] m_ro [DEPTH];
  logic [7:0] m_rw [DEPTH];
  int         m_cnt = 0;
  int         m_len = 0;
  bit         m_in_load = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] img [0:1100];

  typedef struct {
    logic [9:0] a;
    logic       we;
    logic [7:0] d;
    logic [7:0] exp_ro;
    logic [7:0] exp_rw;
  } vec_t;

  vec_t short_tbl [5];
  vec_t rw_tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_len     = 0;
    m_in_load = 1'b0;
    m_done    = 1'b0;
  endtask

  // One clock: predict outputs from the model's pre-edge view, advance the model, compare.
  task automatic step();
    logic [7:0] e_ro, e_rw;
    e_ro = (m_done && int'(a) < m_len) ? m_ro[a] : FILL;
    e_rw = (m_done && int'(a) < m_len) ? m_rw[a] : FILL;
    if (start && !m_in_load) begin
      m_in_load = 1'b1;
      m_done    = 1'b0;
      m_cnt     = 0;
    end else if (m_in_load && ld_valid) begin
      m_ro[m_cnt] = ld_data;
      m_rw[m_cnt] = ld_data;
      m_cnt++;
      if (ld_last || m_cnt == DEPTH) begin
        m_len     = m_cnt;
        m_in_load = 1'b0;
        m_done    = 1'b1;
      end
    end else if (m_done && we && int'(a) < m_len) begin
      m_rw[a] = d;
    end
    tick();
    check("ld_ready", ro_ld_ready, m_in_load);
    check("busy", ro_busy, m_in_load);
    check("done", ro_done, m_done);
    check("len_ro", ro_len, m_len);
    check("len_rw", rw_len, m_len);
    check("q_ro", ro_q, e_ro);
    check("q_rw", rw_q, e_rw);
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer img[0..n-1]; optional random valid gaps, with stray start pulses on gap cycles.
  task automatic stream(input int n, input bit use_last, input bit gaps);
    int  i   = 0;
    int  cyc = 0;
    bit  v;
    while (i < n && cyc < 4000) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_valid = v;
      ld_data  = img[i];
      ld_last  = use_last && (i == n - 1);
      start    = gaps && !v && ($urandom_range(0, 3) == 0);
      step();
      if (v) i++;
      cyc++;
    end
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("stream_budget", cyc < 4000, 1'b1);
    step();
  endtask

  task automatic rand_reads(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) a = 10'($urandom_range(0, DEPTH - 1));
      else            a = 10'($urandom_range(0, (m_len < DEPTH) ? m_len : DEPTH - 1));
      step();
    end
  endtask

  task automatic apply_table(input vec_t t);
    a  = t.a;
    we = t.we;
    d  = t.d;
    step();
    check("tbl_q_ro", ro_q, t.exp_ro);
    check("tbl_q_rw", rw_q, t.exp_rw);
    we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    short_tbl[0] = '{10'd0,    1'b0, 8'h00, 8'h10, 8'h10};
    short_tbl[1] = '{10'd1,    1'b0, 8'h00, 8'h11, 8'h11};
    short_tbl[2] = '{10'd2,    1'b0, 8'h00, 8'h12, 8'h12};
    short_tbl[3] = '{10'd3,    1'b0, 8'h00, FILL,  FILL};
    short_tbl[4] = '{10'd1023, 1'b0, 8'h00, FILL,  FILL};

    rw_tbl[0] = '{10'd2, 1'b1, 8'hAA, 8'hA2, 8'hA2};
    rw_tbl[1] = '{10'd2, 1'b0, 8'h00, 8'hA2, 8'hAA};
    rw_tbl[2] = '{10'd5, 1'b1, 8'h55, FILL,  FILL};
    rw_tbl[3] = '{10'd5, 1'b0, 8'h00, FILL,  FILL};
    rw_tbl[4] = '{10'd3, 1'b1, 8'hBB, 8'hA3, 8'hA3};
    rw_tbl[5] = '{10'd1, 1'b0, 8'h00, 8'hA1, 8'hA1};
    rw_tbl[6] = '{10'd3, 1'b0, 8'h00, 8'hA3, 8'hBB};

    // Reset held for three edges, then idle reads.
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ld_ready", ro_ld_ready, 1'b0);
    check("rst_busy", ro_busy, 1'b0);
    check("rst_done", ro_done, 1'b0);
    check("rst_len", ro_len, 11'd0);
    check("rst_q", ro_q, FILL);
    reset = 1'b1;
    foreach (short_tbl[i]) begin
      a = short_tbl[i].a;
      step();
    end

    // Short load terminated by ld_last.
    img[0] = 8'h10; img[1] = 8'h11; img[2] = 8'h12;
    a = '0;
    begin_load();
    stream(3, 1'b1, 1'b0);
    check("short_len", ro_len, 11'd3);
    foreach (short_tbl[i]) apply_table(short_tbl[i]);

    // Full-depth reload with no ld_last; the 1025th word must be refused.
    for (int i = 0; i < 1025; i++) img[i] = 8'($urandom);
    a = '0;
    begin_load();
    stream(1025, 1'b0, 1'b0);
    check("full_len", ro_len, 11'd1024);
    check("full_ld_ready", ro_ld_ready, 1'b0);
    a = 10'd0;    step();
    check("full_mem0", ro_q, img[0]);
    a = 10'd1023; step();
    check("full_mem_last", ro_q, img[1023]);
    rand_reads(20);

    // 64-word load with random valid gaps and ignored start pulses.
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    a = '0;
    begin_load();
    stream(64, 1'b1, 1'b1);
    check("gap_len", ro_len, 11'd64);
    for (int i = 0; i < 64; i += 9) begin
      a = 10'(i);
      step();
      check("gap_data", ro_q, img[i]);
    end
    a = 10'd64; step();
    rand_reads(30);

    // RW instance vs ROM instance after a 4-word image.
    img[0] = 8'hA0; img[1] = 8'hA1; img[2] = 8'hA2; img[3] = 8'hA3;
    a = '0;
    begin_load();
    stream(4, 1'b1, 1'b0);
    foreach (rw_tbl[i]) apply_table(rw_tbl[i]);

    // Asynchronous reset in the middle of a 20-word load.
    for (int i = 0; i < 20; i++) img[i] = 8'($urandom);
    a = '0;
    begin_load();
    stream(10, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", ro_busy, 1'b0);
    check("mid_rst_ld_ready", ro_ld_ready, 1'b0);
    check("mid_rst_done", ro_done, 1'b0);
    check("mid_rst_len", ro_len, 11'd0);
    check("mid_rst_q", ro_q, FILL);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) img[i] = 8'($urandom);
    begin_load();
    stream(20, 1'b1, 1'b0);
    check("reload_len", ro_len, 11'd20);
    for (int i = 0; i < 21; i++) begin
      a = 10'(i);
      step();
    end
    rand_reads(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_mem.md
# boot_mem

Parametrised byte/word memory that is filled at run time from a streamed boot image instead of from a synthesis-time init file. It sits between the SD/flash loader and the CPU memory decoder. It replaces the fixed-image ROM wherever the system ROM set must be selectable without resynthesis. Optional RW mode lets the block serve as loadable RAM once the image is in.

## Interface
- KB, default 16: size in KiB-equivalent words; DEPTH = KB*1024, AW = $clog2(DEPTH).
- DW, default 8: data width of both the CPU port and the load stream.
- RW, default 0: 0 = CPU write port ignored (ROM); 1 = CPU writes allowed in DONE state.
- FILL, default all-ones: value driven on q whenever the memory is not readable.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; begins a load.
- ld_valid  in  1  load word present on ld_data.
- ld_data  in  DW  load word.
- ld_last  in  1  qualifies ld_valid; final word of image.
- ld_ready  out  1  block accepts a load word this cycle.
- busy  out  1  high in LOAD state.
- done  out  1  high in DONE state; image valid.
- len  out  AW+1  number of words written by the last completed load.
- a  in  AW  CPU word address.
- we  in  1  CPU write strobe (effective only when RW=1).
- d  in  DW  CPU write data.
- q  out  DW  registered CPU read data.

## Operation
- States: IDLE, LOAD, DONE. Reset state is IDLE.
- Reset values: ld_ready=0, busy=0, done=0, len=0, q=FILL, internal write counter cnt=0. Memory array is not cleared.
- IDLE -> LOAD on start. On entry: cnt=0, busy=1, ld_ready=1.
- DONE -> LOAD on start (reload). done drops on entry. len holds its old value until the new load completes.
- start in LOAD is ignored.
- LOAD: each cycle with ld_valid && ld_ready writes ld_data to mem[cnt], then cnt=cnt+1.
- LOAD -> DONE on an accepted word with ld_last=1, or on an accepted word at cnt=DEPTH-1, whichever comes first.
- On that transition: len = cnt+1 (range 1..DEPTH), ld_ready=0, busy=0, done=1.
- Words arriving after the last accepted word are not accepted (ld_ready=0). The counter never wraps; no write ever aliases to address 0.
- CPU read: q is FILL in IDLE and LOAD. In DONE, q = mem[a] for a < len, and q = FILL for a >= len.
- CPU write: in DONE with RW=1, we writes d to mem[a], but only if a < len. Otherwise we is ignored. When RW=0, we is always ignored.
- Read-first: a simultaneous read and write to the same address returns the old data on q; the new data appears on the next read.
- Asynchronous reset mid-load: immediately IDLE, busy=0, ld_ready=0, done=0, len=0. Partial contents are unspecified and must not be read as valid.

## Timing
- ld_ready asserts the cycle after start is sampled. Throughput is one word per clock while ld_valid is held.
- A word is accepted on the edge where ld_valid && ld_ready.
- done and len update on the same edge that writes the final word. ld_ready is low from the following cycle.
- CPU read latency: 1 clock (address on edge N, q valid after edge N). q updates every clock; there is no enable.
- The first DONE cycle reads valid data: the read sampled at the transition edge still returns FILL, and the next edge returns data.
- Memory is inferred as synchronous single-port block RAM. The load and CPU paths are muxed onto that port by state, so no true dual-port is required.

## Test plan
- Reset then idle: hold reset low 3 cycles, release -> q=FILL, done=0, busy=0, ld_ready=0, len=0. Reads at any address return FILL.
- Short load with last: KB=1, start, stream 0x10,0x11,0x12 with ld_last on 0x12 -> len=3, done=1. Reads of a=0..2 give 0x10..0x12 one cycle after the address; a=3 gives FILL.
- Full-depth load: KB=1, stream 1025 words with ld_last never asserted -> DONE after word 1024, len=1024, ld_ready=0 on the next cycle. Word 1025 is not accepted, and mem[0] keeps the first word.
- Backpressure gaps: deassert ld_valid on random cycles during a 64-word load -> all 64 words land at addresses 0..63 in order, len=64.
- RW mode: RW=1 after a 4-word load, write 0xAA to a=2 with a simultaneous read -> q shows the old value, then 0xAA on the next read. A write to a=5 is ignored. With RW=0 the same write leaves a=2 unchanged.
- Reset mid-load: assert reset after 10 of 20 words -> done=0, busy=0, len=0 immediately. A new start then a full 20-word load -> len=20 and correct data.
